seg_display_arbiter: RTL and testbench

- Shares the single 7-segment output port between two segment-pattern requesters, for example a message-scroll sequencer and a host-driven character source.
- Grants one request at a time using round-robin arbitration.
- Holds the granted pattern on the display for a programmable dwell time, then blanks it for a fixed gap before the next grant.
- Sits between the pattern sources and the top-level `uo_out` drive.

---
 rtl/seg_display_arbiter.sv | 133 +++++++++++++
 tb/tb_seg_display_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 7-segment output between two pattern requesters.
// Each grant is shown for a sampled dwell time, then blanked for a fixed gap.
module seg_display_arbiter #(
  parameter int unsigned DWELL_W    = 16,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  input  logic [15:0]        req_seg,
  output logic [1:0]         req_ready,
  input  logic [DWELL_W-1:0] dwell_len,
  input  logic               hold,
  output logic [7:0]         seg_out,
  output logic               busy,
  output logic               owner
);

  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [7:0]         seg_q, seg_d;
  logic               busy_q, busy_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;

  logic               grant_vld;
  logic               grant_idx;
  logic               fire;
  logic [7:0]         grant_seg;

  // Grant selection: a lone requester wins outright, a tie goes to the one not served last.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    if (state_q == StIdle && !hold && !rst) begin
      case (req_valid)
        2'b01: begin grant_vld = 1'b1; grant_idx = 1'b0;    end
        2'b10: begin grant_vld = 1'b1; grant_idx = 1'b1;    end
        2'b11: begin grant_vld = 1'b1; grant_idx = ~last_q; end
        default: ;
      endcase
    end
  end

  // Output process: the only combinational output is the accept vector.
  always_comb begin
    req_ready = {grant_vld & grant_idx, grant_vld & ~grant_idx};
  end

  assign fire      = |(req_valid & req_ready);
  assign grant_seg = grant_idx ? req_seg[15:8] : req_seg[7:0];

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    seg_d   = seg_q;
    busy_d  = busy_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (fire) begin
          state_d = StShow;
          seg_d   = grant_seg;
          owner_d = grant_idx;
          last_d  = grant_idx;
          busy_d  = 1'b1;
          // A zero dwell is treated as a one-cycle dwell.
          dwell_d = (dwell_len == '0) ? '0 : dwell_len - DWELL_W'(1);
        end
      end
      StShow: begin
        if (!hold) begin
          if (dwell_q == '0) begin
            seg_d = 8'h00;
            if (GAP_CYCLES > 0) begin
              state_d = StGap;
              gap_d   = GapLoad;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end else begin
            dwell_d = dwell_q - DWELL_W'(1);
          end
        end
      end
      StGap: begin
        if (!hold) begin
          if (gap_q == '0) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            gap_d = gap_q - GapW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      dwell_q <= '0;
      gap_q   <= '0;
      seg_q   <= 8'h00;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign seg_out = seg_q;
  assign busy    = busy_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Bench for seg_display_arbiter: directed scenarios plus random traffic, checked against
// a schedule-queue model of what the display must show on each future cycle.
module tb_seg_display_arbiter;

  localparam int unsigned DwellW = 4;
  localparam int unsigned GapCycles = 2;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [15:0]       req_seg;
  logic [1:0]        req_ready;
  logic [DwellW-1:0] dwell_len;
  logic              hold;
  logic [7:0]        seg_out;
  logic              busy;
  logic              owner;

  seg_display_arbiter #(
    .DWELL_W    (DwellW),
    .GAP_CYCLES (GapCycles)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_seg   (req_seg),
    .req_ready (req_ready),
    .dwell_len (dwell_len),
    .hold      (hold),
    .seg_out   (seg_out),
    .busy      (busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cycle = 0;

  // Model: the queue holds the display value for each upcoming cycle of the current grant.
  logic [7:0] sched[$];
  logic [7:0] m_seg;
  logic       m_busy;
  logic       m_owner;
  logic       m_last;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [1:0] exp_ready(input logic r, input logic [1:0] v, input logic h);
    if (r || h || m_busy) return 2'b00;
    if (v == 2'b11) return m_last ? 2'b01 : 2'b10;
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic [1:0] v, input logic [15:0] s,
                            input logic [DwellW-1:0] d, input logic h);
    logic [1:0] rdy;
    logic       g;
    int         n;
    if (r) begin
      sched.delete();
      m_seg   = 8'h00;
      m_busy  = 1'b0;
      m_owner = 1'b0;
      m_last  = 1'b1;
    end else if (!h) begin
      rdy = exp_ready(r, v, h);
      if (!m_busy) begin
        if (rdy != 2'b00) begin
          g = rdy[1];
          n = (d == 0) ? 1 : int'(d);
          for (int i = 0; i < n; i++) sched.push_back(g ? s[15:8] : s[7:0]);
          for (int i = 0; i < GapCycles; i++) sched.push_back(8'h00);
          m_owner = g;
          m_last  = g;
          m_busy  = 1'b1;
          m_seg   = sched.pop_front();
        end
      end else if (sched.size() > 0) begin
        m_seg = sched.pop_front();
      end else begin
        m_seg  = 8'h00;
        m_busy = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic [1:0] v, input logic [15:0] s,
                      input logic [DwellW-1:0] d, input logic h, input bit chk);
    rst       = r;
    req_valid = v;
    req_seg   = s;
    dwell_len = d;
    hold      = h;
    @(negedge clk);
    if (chk) begin
      check_eq("req_ready", {6'd0, req_ready}, {6'd0, exp_ready(r, v, h)});
      check_eq("seg_out", seg_out, m_seg);
      check_eq("busy", {7'd0, busy}, {7'd0, m_busy});
      check_eq("owner", {7'd0, owner}, {7'd0, m_owner});
    end
    @(posedge clk);
    model_edge(r, v, s, d, h);
    cycle++;
    #1;
  endtask

  task automatic run(input int n, input logic r, input logic [1:0] v, input logic [15:0] s,
                     input logic [DwellW-1:0] d, input logic h);
    for (int i = 0; i < n; i++) step(r, v, s, d, h, 1'b1);
  endtask

  initial begin
    m_seg = 8'h00; m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 2'b00, 16'h0000, 4'd0, 1'b0, 1'b0);
    run(2, 1'b1, 2'b11, 16'hFFFF, 4'd3, 1'b0);

    // Single request with basic timing, then idle until ready again.
    run(1, 1'b0, 2'b01, 16'h005B, 4'd3, 1'b0);
    run(6, 1'b0, 2'b00, 16'h005B, 4'd3, 1'b0);
    run(1, 1'b0, 2'b01, 16'h005B, 4'd3, 1'b0);
    run(6, 1'b0, 2'b00, 16'h0000, 4'd3, 1'b0);

    // Tie alternation.
    run(10, 1'b0, 2'b11, 16'h4F7E, 4'd1, 1'b0);
    run(4, 1'b0, 2'b00, 16'h0000, 4'd1, 1'b0);

    // Zero dwell on requester 1.
    run(1, 1'b0, 2'b10, 16'h0E00, 4'd0, 1'b0);
    run(4, 1'b0, 2'b00, 16'h0000, 4'd0, 1'b0);

    // Hold stretches dwell; hold in idle blocks the grant.
    run(1, 1'b0, 2'b01, 16'h00AA, 4'd4, 1'b0);
    run(1, 1'b0, 2'b00, 16'h0000, 4'd4, 1'b0);
    run(3, 1'b0, 2'b00, 16'h0000, 4'd4, 1'b1);
    run(8, 1'b0, 2'b00, 16'h0000, 4'd4, 1'b0);
    run(3, 1'b0, 2'b01, 16'h0033, 4'd2, 1'b1);
    run(1, 1'b0, 2'b01, 16'h0033, 4'd2, 1'b0);
    run(6, 1'b0, 2'b00, 16'h0000, 4'd2, 1'b0);

    // Reset mid-show; requester 0 must win the first tie afterwards.
    run(1, 1'b0, 2'b10, 16'h3E00, 4'd5, 1'b0);
    run(2, 1'b0, 2'b00, 16'h0000, 4'd5, 1'b0);
    run(1, 1'b1, 2'b00, 16'h0000, 4'd5, 1'b0);
    run(1, 1'b0, 2'b11, 16'h1234, 4'd1, 1'b0);
    run(4, 1'b0, 2'b00, 16'h0000, 4'd1, 1'b0);

    // Dwell length sampled at grant; maximum dwell too.
    run(1, 1'b0, 2'b01, 16'h0011, 4'd5, 1'b0);
    run(1, 1'b0, 2'b00, 16'h0000, 4'd5, 1'b0);
    run(8, 1'b0, 2'b00, 16'h0000, 4'd2, 1'b0);
    run(1, 1'b0, 2'b10, 16'h2200, 4'd2, 1'b0);
    run(5, 1'b0, 2'b00, 16'h0000, 4'd2, 1'b0);
    run(1, 1'b0, 2'b01, 16'h0077, 4'd15, 1'b0);
    run(18, 1'b0, 2'b00, 16'h0000, 4'd15, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic              r;
      logic              h;
      logic [1:0]        v;
      logic [15:0]       s;
      logic [DwellW-1:0] d;
      r = ($urandom_range(0, 199) == 0);
      h = ($urandom_range(0, 7) == 0);
      v = 2'($urandom_range(0, 3));
      s = 16'($urandom);
      d = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      step(r, v, s, d, h, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
